io_input_debounce: RTL and testbench
====================================

Name: io_input_debounce

Overview:
- Per-channel conditioning stage directly downstream of the muxable IO pad's receive outputs (func_receive bits).
- Synchronises asynchronous pad input bits into the clk domain and rejects glitches shorter than a programmable number of samples.
- Emits a stable level plus single-cycle rise/fall strobes for consumers such as button handlers, UART RX and strobe decoders.
- WIDTH independent channels share one clock, reset and sample strobe.

Parameters:
- WIDTH, 1, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flip-flop depth; legal range >=2.
- DEBOUNCE_CYCLES, 16, consecutive differing samples required to accept a new level; legal range >=1.
- RESET_LEVEL, 1'b0, reset value of synchroniser chain and level output for all channels.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  debounce sample strobe; tie to 1 for per-clock sampling, pulse for prescaled sampling.
- raw_in  input  WIDTH  asynchronous pad inputs (func_receive bits).
- level  output  WIDTH  debounced, synchronised level.
- rise  output  WIDTH  one-cycle pulse when level goes 0->1.
- fall  output  WIDTH  one-cycle pulse when level goes 1->0.

Behaviour:
- Reset (async assert, sync-safe release):
  - all sync stages = RESET_LEVEL; level = RESET_LEVEL; rise = fall = 0; counters = 0.
- Synchroniser:
  - SYNC_STAGES-deep shift chain per channel, clocked every cycle regardless of sample_en.
  - s = last stage output; no logic between stages.
- Counter:
  - CW = $clog2(DEBOUNCE_CYCLES+1) bits per channel.
- Per channel, evaluated on each clk edge where sample_en=1:
  - s == level: counter <= 0.
  - s != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s != level and counter == DEBOUNCE_CYCLES-1: level <= s; counter <= 0; rise <= s; fall <= ~s.
- sample_en=0:
  - counter and level hold.
  - rise/fall <= 0.
- rise/fall:
  - registered; high for exactly the single cycle in which the new level is first visible; never both high.
  - Cleared on every cycle where no transition is accepted.
- Latency, sample_en=1, clean step on raw_in:
  - level changes SYNC_STAGES + DEBOUNCE_CYCLES clock edges after the first edge sampling the new value.
- Glitch rejection: any excursion of s lasting fewer than DEBOUNCE_CYCLES consecutive samples is discarded; the counter restarts from 0 on return.
- DEBOUNCE_CYCLES=1: no filtering; level follows s with one extra register.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous strobes.
- Reset mid-count: the pending transition is discarded and level returns to RESET_LEVEL with no rise/fall strobe.

Optional Feature:
- Macro: IO_DEBOUNCE_EVENT_COUNT_EN.
- Defined:
  - Adds output event_count (WIDTH*8 bits): per channel, an 8-bit saturating counter of accepted transitions (rise or fall).
  - Reset = 0; increments in the same cycle rise|fall is asserted; saturates at 255 with no wrap.
  - Adds input event_clr (1 bit): synchronous clear of all counters; clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Reset: rst=1 with raw_in toggling, RESET_LEVEL=0 -> level=0, rise=fall=0; after release with raw_in=0 held 50 cycles, level stays 0 and no strobes.
- Clean step: WIDTH=1, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, sample_en=1, raw_in 0->1 -> level=1 at edge 6 after the change; rise=1 for exactly that cycle; fall stays 0.
- Glitch reject: same config, raw_in high for 3 cycles then low -> level stays 0, no rise; high for 4 cycles -> level=1 with one rise pulse.
- Prescale: sample_en pulsed every 4th cycle, DEBOUNCE_CYCLES=4 -> acceptance needs 4 strobes, i.e. level changes about 16 cycles after sync; sample_en=0 holds counter mid-count.
- Multi-channel/reset mid-count: WIDTH=2, ch0 rises and ch1 falls (RESET_LEVEL=1 variant) on the same cycle -> rise[0] and fall[1] coincide; rst pulsed at count=2 -> level returns to RESET_LEVEL with no strobe.
- IO_DEBOUNCE_EVENT_COUNT_EN defined: 300 accepted toggles -> event_count=255; event_clr asserted in the same cycle as a rise -> count=0.

Source files
------------

// File: rtl/io_input_debounce.sv
// -----------------------------------------------------------------------------
// io_input_debounce
//
// Per-channel conditioning for asynchronous pad receive bits. Each channel
// passes through a SYNC_STAGES-deep synchroniser and then a debounce filter.
// The filter accepts a new level only after DEBOUNCE_CYCLES consecutive
// enabled samples differ from the current level. When a new level is accepted,
// the block emits a one-cycle rise or fall strobe.
//
// Optional build macro: IO_DEBOUNCE_EVENT_COUNT_EN
//   When defined, the block adds event_clr and event_count. event_count holds
//   one 8-bit saturating count of accepted transitions per channel.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample_en    debounce sample strobe (tie high for per-clock sampling)
//   raw_in       [WIDTH] asynchronous pad inputs
//   level        [WIDTH] debounced, synchronised level
//   rise         [WIDTH] one-cycle pulse on an accepted 0->1 transition
//   fall         [WIDTH] one-cycle pulse on an accepted 1->0 transition
//   event_clr    (macro only) synchronous clear of all event counters
//   event_count  [WIDTH*8] (macro only) per-channel saturating event counts
// -----------------------------------------------------------------------------
module io_input_debounce #(
    parameter int   WIDTH           = 1,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic [WIDTH-1:0]   raw_in,
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
    input  logic               event_clr,
    output logic [WIDTH*8-1:0] event_count,
`endif
    output logic [WIDTH-1:0]   level,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] accept;

    // ---- synchroniser stage: plain shift chain, runs every clock ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {WIDTH{RESET_LEVEL}};
            end
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A transition is accepted on the enabled sample that would otherwise
    // push the counter past DEBOUNCE_CYCLES-1. Therefore the counter never
    // wraps. With DEBOUNCE_CYCLES=1, CNT_LAST is 0 and every difference is
    // accepted immediately.
    always_comb begin
        accept = '0;
        for (int c = 0; c < WIDTH; c++) begin
            accept[c] = sample_en && (s[c] != level[c]) && (cnt_q[c] == CNT_LAST);
        end
    end

    // ---- filter stage: counter, level and strobes ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= {WIDTH{RESET_LEVEL}};
            rise  <= '0;
            fall  <= '0;
            for (int c = 0; c < WIDTH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            // Strobes are rebuilt every cycle, so they drop without an
            // accepted transition, including when sample_en is low.
            rise  <= accept & s;
            fall  <= accept & ~s;
            level <= (level & ~accept) | (s & accept);
            if (sample_en) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if ((s[c] == level[c]) || accept[c]) begin
                        cnt_q[c] <= '0;
                    end else begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
    logic [7:0] evt_q [WIDTH];

    // The counter updates on the same edge that registers rise/fall, so the
    // new count and the strobe become visible together. Clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < WIDTH; c++) begin
                evt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < WIDTH; c++) begin
                if (event_clr) begin
                    evt_q[c] <= '0;
                end else if (accept[c] && (evt_q[c] != 8'hFF)) begin
                    evt_q[c] <= evt_q[c] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        event_count = '0;
        for (int c = 0; c < WIDTH; c++) begin
            event_count[c*8 +: 8] = evt_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_io_input_debounce
//
// Drives three io_input_debounce configurations from shared stimulus and
// compares them against a behavioural model:
//   dut0: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0
//   dut1: SYNC_STAGES=3, DEBOUNCE_CYCLES=3, RESET_LEVEL=1
//   dut2: SYNC_STAGES=2, DEBOUNCE_CYCLES=1, RESET_LEVEL=0
// The model represents the synchroniser as a pure delay line. It represents
// the filter as a run length of enabled samples that disagree with the
// current level.
// -----------------------------------------------------------------------------
module tb_io_input_debounce;

    localparam int NI = 3;
    localparam int W  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_en = 1'b0;
    logic         event_clr = 1'b0;
    logic [W-1:0] raw_in = '0;

    logic [W-1:0] lvl [NI];
    logic [W-1:0] rs  [NI];
    logic [W-1:0] fl  [NI];
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
    logic [W*8-1:0] ec [NI];
`endif

    always #5 clk = ~clk;

    io_input_debounce #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_in),
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
        .event_clr(event_clr), .event_count(ec[0]),
`endif
        .level(lvl[0]), .rise(rs[0]), .fall(fl[0]));

    io_input_debounce #(.WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(3), .RESET_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_in),
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
        .event_clr(event_clr), .event_count(ec[1]),
`endif
        .level(lvl[1]), .rise(rs[1]), .fall(fl[1]));

    io_input_debounce #(.WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)) dut2 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .raw_in(raw_in),
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
        .event_clr(event_clr), .event_count(ec[2]),
`endif
        .level(lvl[2]), .rise(rs[2]), .fall(fl[2]));

    function automatic int ss_of(input int k);
        return (k == 1) ? 3 : 2;
    endfunction

    function automatic int dc_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
    endfunction

    function automatic bit rl_of(input int k);
        return (k == 1);
    endfunction

    // Reference model state.
    bit pipe   [NI][W][4];
    bit m_lvl  [NI][W];
    int m_run  [NI][W];
    bit m_rise [NI][W];
    bit m_fall [NI][W];
    int m_cnt  [NI][W];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < W; c++) begin
                for (int i = 0; i < 4; i++) pipe[k][c][i] = rl_of(k);
                m_lvl[k][c]  = rl_of(k);
                m_run[k][c]  = 0;
                m_rise[k][c] = 1'b0;
                m_fall[k][c] = 1'b0;
                m_cnt[k][c]  = 0;
            end
        end
    endtask

    // One rising clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        bit s_old;
        bit acc;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < W; c++) begin
                    s_old = pipe[k][c][ss_of(k)-1];
                    for (int i = 3; i > 0; i--) pipe[k][c][i] = pipe[k][c][i-1];
                    pipe[k][c][0] = raw_in[c];
                    acc = 1'b0;
                    m_rise[k][c] = 1'b0;
                    m_fall[k][c] = 1'b0;
                    if (sample_en) begin
                        if (s_old != m_lvl[k][c]) begin
                            m_run[k][c]++;
                            if (m_run[k][c] == dc_of(k)) begin
                                m_lvl[k][c]  = s_old;
                                m_run[k][c]  = 0;
                                acc          = 1'b1;
                                m_rise[k][c] = s_old;
                                m_fall[k][c] = !s_old;
                            end
                        end else begin
                            m_run[k][c] = 0;
                        end
                    end
                    if (event_clr) m_cnt[k][c] = 0;
                    else if (acc && m_cnt[k][c] < 255) m_cnt[k][c]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [W-1:0]   e_l, e_r, e_f;
        logic [W*8-1:0] e_c;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < W; c++) begin
                e_l[c] = m_lvl[k][c];
                e_r[c] = m_rise[k][c];
                e_f[c] = m_fall[k][c];
                e_c[c*8 +: 8] = 8'(m_cnt[k][c]);
            end
            check($sformatf("%s dut%0d level", tag, k), 32'(lvl[k]), 32'(e_l));
            check($sformatf("%s dut%0d rise", tag, k), 32'(rs[k]), 32'(e_r));
            check($sformatf("%s dut%0d fall", tag, k), 32'(fl[k]), 32'(e_f));
`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
            check($sformatf("%s dut%0d event_count", tag, k), 32'(ec[k]), 32'(e_c));
`endif
        end
    endtask

    task automatic cycle(input logic [W-1:0] r, input logic en, input logic rst_i,
                         input logic clr, input string tag);
        @(negedge clk);
        raw_in    = r;
        sample_en = en;
        rst       = rst_i;
        event_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int lat;
        int n_rise;
        int n_coinc;
        int done;
        int hold;
        logic [W-1:0] r;
        model_reset();

        // Reset with toggling inputs.
        for (int i = 0; i < 6; i++) cycle(W'($urandom), 1'b1, 1'b1, 1'b0, "reset");
        check("reset_level_dut0", 32'(lvl[0]), 32'h0);
        check("reset_level_dut1", 32'(lvl[1]), 32'h3);
        for (int i = 0; i < 50; i++) cycle('0, 1'b1, 1'b0, 1'b0, "idle");
        check("idle_level_dut0", 32'(lvl[0]), 32'h0);

        // Clean step: level moves on edge SYNC_STAGES+DEBOUNCE_CYCLES.
        lat = 0;
        n_rise = 0;
        for (int i = 1; i <= 12; i++) begin
            cycle(2'b11, 1'b1, 1'b0, 1'b0, "step");
            if (lat == 0 && lvl[0][0]) lat = i;
            if (rs[0][0]) n_rise++;
        end
        check("step_latency_dut0", 32'(lat), 32'd6);
        check("step_rise_pulses_dut0", 32'(n_rise), 32'd1);

        // Glitch rejection: 3 high samples are discarded; 4 are accepted.
        for (int i = 0; i < 12; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0, "settle");
        n_rise = 0;
        for (int i = 0; i < 3; i++) begin cycle(2'b01, 1'b1, 1'b0, 1'b0, "glitch3"); if (rs[0][0]) n_rise++; end
        for (int i = 0; i < 10; i++) begin cycle(2'b00, 1'b1, 1'b0, 1'b0, "glitch3"); if (rs[0][0]) n_rise++; end
        check("glitch3_rise_dut0", 32'(n_rise), 32'd0);
        n_rise = 0;
        for (int i = 0; i < 4; i++) begin cycle(2'b01, 1'b1, 1'b0, 1'b0, "glitch4"); if (rs[0][0]) n_rise++; end
        for (int i = 0; i < 2; i++) begin cycle(2'b00, 1'b1, 1'b0, 1'b0, "glitch4"); if (rs[0][0]) n_rise++; end
        check("glitch4_rise_dut0", 32'(n_rise), 32'd1);
        for (int i = 0; i < 12; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0, "settle");

        // Prescaled sampling: one strobe every fourth cycle.
        for (int i = 0; i < 40; i++) cycle(2'b01, (i % 4) == 3, 1'b0, 1'b0, "prescale_up");
        check("prescale_level_dut0", 32'(lvl[0][0]), 32'd1);
        for (int i = 0; i < 40; i++) cycle(2'b00, (i % 4) == 1, 1'b0, 1'b0, "prescale_dn");

        // Simultaneous rise on ch0 and fall on ch1.
        for (int i = 0; i < 15; i++) cycle(2'b10, 1'b1, 1'b0, 1'b0, "pre_multi");
        n_coinc = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0, "multi");
            if (rs[1] == 2'b01 && fl[1] == 2'b10) n_coinc++;
        end
        check("multi_coincident_dut1", 32'(n_coinc), 32'd1);

        // Reset during a pending count.
        for (int i = 0; i < 4; i++) cycle(2'b10, 1'b1, 1'b0, 1'b0, "midcount");
        cycle(2'b10, 1'b1, 1'b1, 1'b0, "midreset");
        check("midreset_level_dut0", 32'(lvl[0]), 32'h0);
        check("midreset_level_dut1", 32'(lvl[1]), 32'h3);
        check("midreset_strobes_dut1", 32'({rs[1], fl[1]}), 32'h0);
        for (int i = 0; i < 10; i++) cycle(2'b10, 1'b1, 1'b0, 1'b0, "postreset");

        // Randomized traffic with variable hold times and sparse resets.
        done = 0;
        while (done < 2000) begin
            r = W'($urandom);
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                      $urandom_range(0, 63) == 0, "rand");
                done++;
            end
        end

`ifdef IO_DEBOUNCE_EVENT_COUNT_EN
        cycle(2'b00, 1'b1, 1'b1, 1'b0, "ev_reset");
        cycle(2'b00, 1'b1, 1'b0, 1'b1, "ev_clr");
        for (int i = 0; i < 300; i++) cycle((i % 2) ? 2'b11 : 2'b00, 1'b1, 1'b0, 1'b0, "ev_toggle");
        check("ev_saturated_dut2", 32'(ec[2][7:0]), 32'd255);
        for (int i = 0; i < 5; i++) cycle(2'b00, 1'b1, 1'b0, 1'b0, "ev_settle");
        cycle(2'b01, 1'b1, 1'b0, 1'b0, "ev_step");
        cycle(2'b01, 1'b1, 1'b0, 1'b0, "ev_step");
        cycle(2'b01, 1'b1, 1'b0, 1'b1, "ev_clr_rise");
        check("ev_clr_rise_strobe_dut2", 32'(rs[2][0]), 32'd1);
        check("ev_clr_wins_dut2", 32'(ec[2][7:0]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
